// File: rtl/databus_pkg.sv
// Shared types and constants for the databus local-memory responder.
package databus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_e;

  localparam int BURST_CNT_W = 16;

  // Byte-offset bits stripped from a databus address for a given beat width.
  function automatic int offset_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/databus_skid_buffer.sv
// Two-entry FIFO that absorbs RAM read latency between issue and delivery.
module databus_skid_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_r [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;

  // Storage, pointers and occupancy; flush empties the buffer.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      mem_r[0] <= {DATA_W{1'b0}};
      mem_r[1] <= {DATA_W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/databus_responder.sv
// Databus burst responder serving read/write bursts from a local single-port RAM.
module databus_responder
  import databus_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int MEM_ADDR_W = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   databus_valid_i,
  output logic                   databus_ready_o,
  input  logic [AXI_ADDR_W-1:0]  databus_addr_i,
  input  logic [LEN_W-1:0]       databus_len_i,
  input  logic                   databus_rnw_i,
  input  logic [DATA_W-1:0]      databus_wdata_i,
  input  logic [DATA_W/8-1:0]    databus_wstrb_i,
  output logic [DATA_W-1:0]      databus_rdata_o,
  output logic                   databus_last_o,
  output logic                   mem_en_o,
  output logic [DATA_W/8-1:0]    mem_we_o,
  output logic [MEM_ADDR_W-1:0]  mem_addr_o,
  output logic [DATA_W-1:0]      mem_wdata_o,
  input  logic [DATA_W-1:0]      mem_rdata_i,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [BURST_CNT_W-1:0] burst_cnt_o
);

  localparam int OFFSET_W = offset_w(DATA_W);
  localparam int STRB_W   = DATA_W / 8;

  state_e                 state_r;
  logic [MEM_ADDR_W-1:0]  base_r;
  logic [LEN_W-1:0]       beats_r;
  logic [LEN_W-1:0]       idx_r;
  logic [LEN_W-1:0]       issued_r;
  logic                   in_flight_r;
  logic                   err_r;
  logic [BURST_CNT_W-1:0] burst_cnt_r;

  logic                   ready_s;
  logic                   last_idx_s;
  logic                   hs_s;
  logic                   pop_s;
  logic                   issue_s;
  logic [DATA_W-1:0]      skid_dout_s;
  logic [1:0]             skid_count_s;
  logic                   unused_addr_s;

  assign unused_addr_s = ^databus_addr_i;

  // Beat acceptance depends only on state and buffered data, never on valid.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      ST_WR:   ready_s = 1'b1;
      ST_RD:   ready_s = (skid_count_s != 2'd0);
      default: ready_s = 1'b0;
    endcase
  end

  assign last_idx_s = (idx_r == (beats_r - LEN_W'(1)));
  assign hs_s       = databus_valid_i && ready_s && !rst_i;
  assign pop_s      = hs_s && (state_r == ST_RD);

  // Counting a same-cycle pop as free space keeps reads at one beat per cycle
  // while still bounding buffered plus in-flight data to two entries.
  always_comb begin
    issue_s = 1'b0;
    if ((state_r == ST_RD) && !rst_i && (issued_r < beats_r)) begin
      issue_s = ((skid_count_s + {1'b0, in_flight_r}) < 2'd2) || pop_s;
    end else begin
      issue_s = 1'b0;
    end
  end

  // RAM port: writes pass straight through on a handshake, reads follow issue.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = {STRB_W{1'b0}};
    mem_addr_o  = {MEM_ADDR_W{1'b0}};
    mem_wdata_o = {DATA_W{1'b0}};
    case (state_r)
      ST_WR: begin
        if (hs_s) begin
          mem_en_o    = 1'b1;
          mem_we_o    = databus_wstrb_i;
          mem_addr_o  = base_r + MEM_ADDR_W'(idx_r);
          mem_wdata_o = databus_wdata_i;
        end else begin
          mem_en_o    = 1'b0;
        end
      end
      ST_RD: begin
        if (issue_s) begin
          mem_en_o   = 1'b1;
          mem_addr_o = base_r + MEM_ADDR_W'(issued_r);
        end else begin
          mem_en_o   = 1'b0;
        end
      end
      default: mem_en_o = 1'b0;
    endcase
  end

  // Burst FSM with capture, beat counting and completion bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      base_r      <= {MEM_ADDR_W{1'b0}};
      beats_r     <= {LEN_W{1'b0}};
      idx_r       <= {LEN_W{1'b0}};
      issued_r    <= {LEN_W{1'b0}};
      in_flight_r <= 1'b0;
      err_r       <= 1'b0;
      burst_cnt_r <= {BURST_CNT_W{1'b0}};
    end else begin
      in_flight_r <= issue_s;
      case (state_r)
        ST_IDLE: begin
          if (databus_valid_i) begin
            base_r   <= MEM_ADDR_W'(databus_addr_i >> OFFSET_W);
            idx_r    <= {LEN_W{1'b0}};
            issued_r <= {LEN_W{1'b0}};
            if (databus_len_i == {LEN_W{1'b0}}) begin
              beats_r <= LEN_W'(1);
              err_r   <= 1'b1;
            end else begin
              beats_r <= databus_len_i;
            end
            state_r <= databus_rnw_i ? ST_RD : ST_WR;
          end
        end
        ST_WR: begin
          if (hs_s) begin
            idx_r <= idx_r + LEN_W'(1);
            if (last_idx_s) begin
              state_r     <= ST_IDLE;
              burst_cnt_r <= burst_cnt_r + BURST_CNT_W'(1);
            end
          end
        end
        ST_RD: begin
          if (issue_s) begin
            issued_r <= issued_r + LEN_W'(1);
          end
          if (pop_s) begin
            idx_r <= idx_r + LEN_W'(1);
            if (last_idx_s) begin
              state_r     <= ST_IDLE;
              burst_cnt_r <= burst_cnt_r + BURST_CNT_W'(1);
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  databus_skid_buffer #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i (clk_i),
    .flush (rst_i),
    .push  (in_flight_r),
    .pop   (pop_s),
    .din   (mem_rdata_i),
    .dout  (skid_dout_s),
    .count (skid_count_s)
  );

  assign databus_ready_o = ready_s;
  assign databus_last_o  = ready_s && last_idx_s;
  assign databus_rdata_o = skid_dout_s;
  assign busy_o          = (state_r != ST_IDLE);
  assign err_o           = err_r;
  assign burst_cnt_o     = burst_cnt_r;

endmodule
